// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer front end.
//   SECS_PER_MIN : increment applied by one MIN button step
//   COUNT_W      : width of the seconds preset
//   MAX_SECS     : default saturation ceiling (59:59)
//   rep_state_t  : per-button auto-repeat state encoding
package egg_timer_pkg;

  localparam int SECS_PER_MIN = 60;
  localparam int COUNT_W      = 12;
  localparam int MAX_SECS     = 3599;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/press_repeat.sv
// Edge-detect plus auto-repeat for one debounced button.
// A fresh press issues a request at once. Holding the button issues another
// request after DELAY_CYC cycles, then one every RATE_CYC cycles.
//   clk   : system clock
//   rst   : synchronous reset, active low
//   en    : configuration enable; low forces the FSM idle
//   level : debounced button level
//   req   : increment request, valid in the same cycle as the press/tick
module press_repeat
  import egg_timer_pkg::*;
#(
  parameter int DELAY_CYC = 2_500_000,
  parameter int RATE_CYC  = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic level,
  output logic req
);

  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  rep_state_t         state_reg;
  logic               prev_reg;
  logic [TIMER_W-1:0] timer_reg;

  logic active;
  logic press;
  logic tick;

  // Holding a button while en rises leaves prev_reg high, so no press is
  // seen until the button is released and pressed again.
  assign active = en && level;
  assign press  = active && !prev_reg && (state_reg == ST_IDLE);
  assign tick   = active && (state_reg != ST_IDLE) && (timer_reg == '0);
  assign req    = press || tick;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      prev_reg  <= 1'b0;
      timer_reg <= '0;
    end else begin
      prev_reg <= level;
      if (!active) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (!prev_reg) begin
              state_reg <= ST_DELAY;
              timer_reg <= TIMER_W'(DELAY_CYC - 1);
            end
          end
          ST_DELAY: begin
            if (timer_reg == '0) begin
              state_reg <= ST_REPEAT;
              timer_reg <= TIMER_W'(RATE_CYC - 1);
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          ST_REPEAT: begin
            if (timer_reg == '0) begin
              timer_reg <= TIMER_W'(RATE_CYC - 1);
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/time_entry.sv
// Turns MIN/SEC button levels into the seconds preset for the countdown timer.
//   clk      : system clock (clk_5MHz)
//   rst      : synchronous reset, active low
//   cfg_en   : 1 = cook_time configuration mode
//   clear    : synchronous clear of the preset (works regardless of cfg_en)
//   mins_btn : debounced MIN button level
//   secs_btn : debounced SEC button level
//   count    : current preset in binary seconds
//   step     : one-cycle pulse whenever a button changed count
//   at_max   : count equals MAX_SECS
module time_entry #(
  parameter int COUNT_W   = egg_timer_pkg::COUNT_W,
  parameter int MAX_SECS  = egg_timer_pkg::MAX_SECS,
  parameter int DELAY_CYC = 2_500_000,
  parameter int RATE_CYC  = 500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic               clear,
  input  logic               mins_btn,
  input  logic               secs_btn,
  output logic [COUNT_W-1:0] count,
  output logic               step,
  output logic               at_max
);

  import egg_timer_pkg::*;

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_SECS);

  logic mins_req;
  logic secs_req;

  logic [COUNT_W-1:0] count_reg;
  logic               step_reg;
  logic [COUNT_W:0]   inc;
  logic [COUNT_W:0]   sum;

  press_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_mins (
    .clk   (clk),
    .rst   (rst),
    .en    (cfg_en),
    .level (mins_btn),
    .req   (mins_req)
  );

  press_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_secs (
    .clk   (clk),
    .rst   (rst),
    .en    (cfg_en),
    .level (secs_btn),
    .req   (secs_req)
  );

  // A simultaneous secs request is simply dropped in favour of minutes.
  assign inc = mins_req ? (COUNT_W + 1)'(SECS_PER_MIN) : (COUNT_W + 1)'(1);
  assign sum = {1'b0, count_reg} + inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
      step_reg  <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      step_reg  <= 1'b0;
    end else if ((mins_req || secs_req) && (count_reg != MAX_VAL)) begin
      count_reg <= (sum > {1'b0, MAX_VAL}) ? MAX_VAL : sum[COUNT_W-1:0];
      step_reg  <= 1'b1;
    end else begin
      step_reg  <= 1'b0;
    end
  end

  assign count  = count_reg;
  assign step   = step_reg;
  assign at_max = (count_reg == MAX_VAL);

endmodule
